// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the datapath result mux.
// Holds the operand width, funct codes, the step mode encoding and the FSM state type.
package hilo_muldiv_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply or restoring shift-subtract for divide.
// i_hi/i_lo carry P_hi/P_lo (multiply) or R/Q (divide); i_opnd is the multiplicand or divisor.
module muldiv_step
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_quo_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // The 33-bit sum keeps the carry that shifts back into P_hi.
    assign w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    assign w_rem_sh = {i_hi, i_lo[WIDTH-1]};
    assign w_quo_sh = {i_lo[WIDTH-2:0], 1'b0};
    assign w_fits   = (w_rem_sh >= {1'b0, i_opnd});
    // Only taken when the shifted remainder covers the divisor, so WIDTH bits suffice.
    assign w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;

    // Select the next working-register values for the active mode.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_mode == MODE_DIV) begin
            if (w_fits) begin
                o_hi = w_diff;
                o_lo = {w_quo_sh[WIDTH-1:1], 1'b1};
            end else begin
                o_hi = w_rem_sh[WIDTH-1:0];
                o_lo = w_quo_sh;
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle unsigned MULTU/DIVU unit owning the HI/LO register pair.
// One bit per clock; HI/LO update together with a single-cycle done pulse.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int         WIDTH = DATA_WIDTH,
    parameter logic [5:0] MULTU = FUNCT_MULTU,
    parameter logic [5:0] DIVU  = FUNCT_DIVU
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    muldiv_state_e    r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_mode;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_mode = (r_state == ST_DIV) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode (w_mode),
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_hi_nxt),
        .o_lo   (w_lo_nxt)
    );

    // Control FSM, iteration counter, working registers and the HI/LO pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= {CNT_W{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= {WIDTH{1'b0}};
            r_opnd   <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && (Signal == MULTU)) begin
                        r_state  <= ST_MUL;
                        r_busy   <= 1'b1;
                        r_count  <= {CNT_W{1'b0}};
                        r_acc_hi <= {WIDTH{1'b0}};
                        r_acc_lo <= dataB;
                        r_opnd   <= dataA;
                    end else if (start && (Signal == DIVU)) begin
                        r_state  <= ST_DIV;
                        r_busy   <= 1'b1;
                        r_count  <= {CNT_W{1'b0}};
                        r_acc_hi <= {WIDTH{1'b0}};
                        r_acc_lo <= dataA;
                        r_opnd   <= dataB;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc_hi <= w_hi_nxt;
                    r_acc_lo <= w_lo_nxt;
                    r_count  <= r_count + CNT_W'(1);
                    // The last iteration result goes straight to HI/LO.
                    if (r_count == LAST_ITER) begin
                        r_hi    <= w_hi_nxt;
                        r_lo    <= w_lo_nxt;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign HiOut = r_hi;
    assign LoOut = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO and accept cycle are queued at issue
// and compared against the DUT when its done pulse appears.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [5:0]   Signal;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    hilo_muldiv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .HiOut  (HiOut),
        .LoOut  (LoOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("hi", {32'd0, HiOut}, {32'd0, e.hi});
                check_val("lo", {32'd0, LoOut}, {32'd0, e.lo});
                check_val("latency", 64'(cyc - e.acc_cyc), 64'd32);
                check_val("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Issue one command; caller is before the accepting edge. Optionally queues the expectation.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        logic [63:0] p;
        exp_t e;
        dataA  = a;
        dataB  = b;
        Signal = f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            if (f == 6'b011001) begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end else if (b == 32'd0) begin
                e.hi = a;
                e.lo = 32'hFFFF_FFFF;
            end else begin
                e.hi = a % b;
                e.lo = a / b;
            end
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the done pulse; returns the number of busy cycles seen before it.
    task automatic wait_done(output int nb);
        int n;
        n  = 0;
        nb = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            if (busy) nb++;
            n++;
            @(negedge clk);
        end
        if (!done) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int nb;
        int dc0;
        bit saw_busy;
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;

        rst_n  = 1'b0;
        start  = 1'b0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = 6'b000000;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_hi", {32'd0, HiOut}, 64'd0);
        check_val("rst_lo", {32'd0, LoOut}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(6'b011001, 32'd7, 32'd6, 1'b1);
        wait_done(nb);
        check_val("busy_cycles", 64'(nb), 64'd32);
        @(negedge clk);

        do_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(nb);
        @(negedge clk);

        do_op(6'b011011, 32'd100, 32'd7, 1'b1);
        wait_done(nb);
        // Back-to-back accept in the done cycle, divide by zero.
        do_op(6'b011011, 32'h1234_5678, 32'd0, 1'b1);
        wait_done(nb);
        check_val("b2b_busy_cycles", 64'(nb), 64'd32);
        @(negedge clk);

        dc0 = done_cnt;
        do_op(6'b011001, 32'd3, 32'd5, 1'b1);
        repeat (9) @(negedge clk);
        dataA  = 32'd9;
        dataB  = 32'd3;
        Signal = 6'b011011;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(nb);
        repeat (40) @(negedge clk);
        check_val("single_done", 64'(done_cnt - dc0), 64'd1);

        dc0      = done_cnt;
        hi0      = HiOut;
        lo0      = LoOut;
        saw_busy = 1'b0;
        Signal   = 6'b100000;
        dataA    = 32'd11;
        dataB    = 32'd22;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check_val("add_busy", {63'd0, saw_busy}, 64'd0);
        check_val("add_done", 64'(done_cnt - dc0), 64'd0);
        check_val("add_hi", {32'd0, HiOut}, {32'd0, hi0});
        check_val("add_lo", {32'd0, LoOut}, {32'd0, lo0});

        do_op(6'b011001, 32'd7, 32'd6, 1'b1);
        wait_done(nb);
        @(negedge clk);
        check_val("pre_rst_lo", {32'd0, LoOut}, 64'd42);
        do_op(6'b011011, 32'd100, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_val("mid_rst_done", {63'd0, done}, 64'd0);
        check_val("mid_rst_hi", {32'd0, HiOut}, 64'd0);
        check_val("mid_rst_lo", {32'd0, LoOut}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_busy", {63'd0, busy}, 64'd0);
        do_op(6'b011001, 32'd2, 32'd2, 1'b1);
        wait_done(nb);
        repeat (3) @(negedge clk);
        check_val("final_lo", {32'd0, LoOut}, 64'd4);
        check_val("queue_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
